// File: rtl/inference_seq.sv
// Sequencer for the systolic MAC array: decodes ahb_sub control edges, steps the array through
// weight load, input streaming, drain and activation, and produces the bus-visible status/errors.
module inference_seq #(
  parameter int unsigned ARRAY_DIM = 4,
  parameter int unsigned ACT_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ctrl_reg,
  input  logic        wr_en_push,
  input  logic        is_weight,
  input  logic        wbuf_empty,
  input  logic        ibuf_empty,
  output logic        wbuf_pop,
  output logic        ibuf_pop,
  output logic        weight_load,
  output logic        array_en,
  output logic        acc_clear,
  output logic        act_en,
  output logic        out_valid,
  output logic [7:0]  status_reg,
  output logic [15:0] err_reg
);

  localparam int unsigned CntW  = $clog2(2 * ARRAY_DIM + ACT_LAT + 1);
  localparam int unsigned PendW = $clog2(ARRAY_DIM + 1);

  localparam logic [CntW-1:0]  RowsC   = CntW'(ARRAY_DIM);
  localparam logic [CntW-1:0]  DrainC  = CntW'(2 * ARRAY_DIM - 1);
  localparam logic [CntW-1:0]  ActC    = CntW'(ACT_LAT);
  localparam logic [PendW-1:0] PendMax = PendW'(ARRAY_DIM);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StAct, StDone} state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic [7:0]       r_ctrl;
  logic [PendW-1:0] r_w_pend, r_i_pend;
  logic [3:0]       r_err;
  logic             r_done, r_wl;
  logic             r_wbuf_pop, r_ibuf_pop, r_weight_load, r_array_en;
  logic             r_acc_clear, r_act_en, r_out_valid;

  logic [7:0] w_pulse;
  logic       w_start, w_lw, w_clr, w_busy;
  logic       w_i_push, w_w_push;
  logic [3:0] w_err_set;
  logic       w_unused;

  assign w_pulse  = ctrl_reg & ~r_ctrl;
  assign w_start  = w_pulse[0];
  assign w_lw     = w_pulse[1];
  assign w_clr    = w_pulse[7];
  assign w_busy   = (r_state != StIdle) && (r_state != StDone);
  assign w_i_push = wr_en_push && !is_weight;
  assign w_w_push = wr_en_push && is_weight;

  assign w_err_set[0] = (w_start || w_lw) && w_busy;
  assign w_err_set[1] = w_w_push && w_busy;
  assign w_err_set[2] = (r_state == StIdle) && w_start && !w_lw && !r_wl;
  assign w_err_set[3] = w_i_push && (r_i_pend == PendMax) && !r_ibuf_pop;

  // w_pending is tracked for the datapath contract but nothing here consumes it.
  assign w_unused = ^{ctrl_reg[6:2], r_w_pend};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_ctrl        <= '0;
      r_done        <= 1'b0;
      r_wl          <= 1'b0;
      r_wbuf_pop    <= 1'b0;
      r_ibuf_pop    <= 1'b0;
      r_weight_load <= 1'b0;
      r_array_en    <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_act_en      <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      r_ctrl        <= ctrl_reg;
      r_wbuf_pop    <= 1'b0;
      r_ibuf_pop    <= 1'b0;
      r_weight_load <= 1'b0;
      r_array_en    <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_act_en      <= 1'b0;
      r_out_valid   <= 1'b0;
      if (w_clr) r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_lw) begin
            r_state       <= StLoadW;
            r_wl          <= 1'b0;
            r_wbuf_pop    <= !wbuf_empty;
            r_weight_load <= !wbuf_empty;
            r_cnt         <= wbuf_empty ? '0 : CntW'(1);
          end else if (w_start && r_wl) begin
            // First row is popped in the same cycle the accumulators clear.
            r_state     <= StStream;
            r_acc_clear <= 1'b1;
            r_done      <= 1'b0;
            r_ibuf_pop  <= !ibuf_empty;
            r_array_en  <= !ibuf_empty;
            r_cnt       <= ibuf_empty ? '0 : CntW'(1);
          end
        end
        StLoadW: begin
          if (r_cnt == RowsC) begin
            r_state <= StIdle;
            r_wl    <= 1'b1;
          end else if (!wbuf_empty) begin
            r_wbuf_pop    <= 1'b1;
            r_weight_load <= 1'b1;
            r_cnt         <= r_cnt + CntW'(1);
          end
        end
        StStream: begin
          if (r_cnt == RowsC) begin
            r_state    <= StDrain;
            r_array_en <= 1'b1;
            r_cnt      <= CntW'(1);
          end else if (!ibuf_empty) begin
            r_ibuf_pop <= 1'b1;
            r_array_en <= 1'b1;
            r_cnt      <= r_cnt + CntW'(1);
          end
        end
        StDrain: begin
          if (r_cnt == DrainC) begin
            r_state  <= StAct;
            r_act_en <= 1'b1;
            r_cnt    <= CntW'(1);
          end else begin
            r_array_en <= 1'b1;
            r_cnt      <= r_cnt + CntW'(1);
          end
        end
        StAct: begin
          if (r_cnt == ActC) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            r_act_en <= 1'b1;
            r_cnt    <= r_cnt + CntW'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= '0;
      r_i_pend <= '0;
      r_w_pend <= '0;
    end else begin
      // A new error in the same cycle as soft_clear survives the clear.
      r_err <= (w_clr ? 4'b0 : r_err) | w_err_set;
      if (w_clr) begin
        r_i_pend <= '0;
      end else if (w_i_push && !r_ibuf_pop && (r_i_pend != PendMax)) begin
        r_i_pend <= r_i_pend + PendW'(1);
      end else if (!w_i_push && r_ibuf_pop && (r_i_pend != '0)) begin
        r_i_pend <= r_i_pend - PendW'(1);
      end
      if (w_clr) begin
        r_w_pend <= '0;
      end else if (w_w_push && !r_wbuf_pop && (r_w_pend != PendMax)) begin
        r_w_pend <= r_w_pend + PendW'(1);
      end else if (!w_w_push && r_wbuf_pop && (r_w_pend != '0)) begin
        r_w_pend <= r_w_pend - PendW'(1);
      end
    end
  end

  assign wbuf_pop    = r_wbuf_pop;
  assign ibuf_pop    = r_ibuf_pop;
  assign weight_load = r_weight_load;
  assign array_en    = r_array_en;
  assign acc_clear   = r_acc_clear;
  assign act_en      = r_act_en;
  assign out_valid   = r_out_valid;
  assign status_reg  = {4'b0, |r_err, r_wl, r_done, w_busy};
  assign err_reg     = {12'b0, r_err};

endmodule

// File: tb/tb_inference_seq.sv
// Self-checking bench for inference_seq: directed steps plus randomized buffer stalls, checked
// cycle by cycle against a tile-level timeline model.
module tb_inference_seq;

  localparam int Dim    = 4;
  localparam int ActLat = 2;
  localparam int Lat    = Dim + (2 * Dim - 1) + ActLat + 1;

  localparam logic [6:0] VWp  = 7'h40;
  localparam logic [6:0] VIp  = 7'h20;
  localparam logic [6:0] VWl  = 7'h10;
  localparam logic [6:0] VAe  = 7'h08;
  localparam logic [6:0] VAc  = 7'h04;
  localparam logic [6:0] VAct = 7'h02;
  localparam logic [6:0] VOv  = 7'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ctrl_reg;
  logic        wr_en_push, is_weight, wbuf_empty, ibuf_empty;
  logic        wbuf_pop, ibuf_pop, weight_load, array_en, acc_clear, act_en, out_valid;
  logic [7:0]  status_reg;
  logic [15:0] err_reg;

  int n_chk  = 0;
  int n_fail = 0;

  // Bench-side view of the sticky status flags.
  logic       m_wl   = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] m_err  = 4'h0;

  inference_seq #(.ARRAY_DIM(Dim), .ACT_LAT(ActLat)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_reg   (ctrl_reg),
    .wr_en_push (wr_en_push),
    .is_weight  (is_weight),
    .wbuf_empty (wbuf_empty),
    .ibuf_empty (ibuf_empty),
    .wbuf_pop   (wbuf_pop),
    .ibuf_pop   (ibuf_pop),
    .weight_load(weight_load),
    .array_en   (array_en),
    .acc_clear  (acc_clear),
    .act_en     (act_en),
    .out_valid  (out_valid),
    .status_reg (status_reg),
    .err_reg    (err_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] vec();
    return {wbuf_pop, ibuf_pop, weight_load, array_en, acc_clear, act_en, out_valid};
  endfunction

  function automatic logic [7:0] st(input logic busy);
    return {4'b0, |m_err, m_wl, m_done, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rows(input logic w, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en_push = 1'b1;
      is_weight  = w;
      tick();
    end
    wr_en_push = 1'b0;
    is_weight  = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    ctrl_reg = v;
    tick();
    ctrl_reg = 8'h00;
  endtask

  // Empty-flag pattern: a 0 means a row is available at that edge; ends on the Dim-th row.
  task automatic gen_emp(input bit rnd, input int stall_at, input int stall_len, output bit q[$]);
    int ones = 0;
    int stalls = 0;
    bit b;
    q = {};
    while (ones < Dim) begin
      if (rnd) b = (stalls < 6) && ($urandom_range(0, 3) == 0);
      else     b = (ones == stall_at) && (stalls < stall_len);
      q.push_back(b);
      if (b) stalls++;
      else   ones++;
    end
  endtask

  task automatic do_load(input logic [7:0] cv, input bit rnd);
    bit emp[$];
    gen_emp(rnd, 0, 0, emp);
    ctrl_reg = cv;
    m_wl = 1'b0;
    foreach (emp[k]) begin
      wbuf_empty = emp[k];
      tick();
      ctrl_reg = 8'h00;
      chk("load_vec", 16'(vec()), 16'(emp[k] ? 7'h00 : (VWp | VWl)));
      chk("load_status", 16'(status_reg), 16'(st(1'b1)));
    end
    wbuf_empty = 1'b1;
    tick();
    m_wl = 1'b1;
    chk("load_end_vec", 16'(vec()), 16'h0);
    chk("load_end_status", 16'(status_reg), 16'(st(1'b0)));
  endtask

  task automatic do_stream(input int stall_at, input int stall_len, input bit rnd, input bit inj);
    bit         emp[$];
    logic [6:0] exp_q[$];
    int         ov_cycle = 0;
    int         stalls;
    logic [3:0] err_base;
    gen_emp(rnd, stall_at, stall_len, emp);
    stalls = emp.size() - Dim;
    foreach (emp[k]) exp_q.push_back(((k == 0) ? VAc : 7'h00) | (emp[k] ? 7'h00 : (VIp | VAe)));
    repeat (2 * Dim - 1) exp_q.push_back(VAe);
    repeat (ActLat) exp_q.push_back(VAct);
    exp_q.push_back(VOv);
    err_base = m_err;
    m_done   = 1'b0;
    ctrl_reg = 8'h01;
    for (int c = 0; c < exp_q.size(); c++) begin
      ibuf_empty = (c < emp.size()) ? emp[c] : 1'b1;
      if (c > 0) ctrl_reg = (inj && c == 2) ? 8'h01 : 8'h00;
      wr_en_push = inj && (c == 2);
      is_weight  = inj && (c == 2);
      tick();
      if (inj && c >= 2) m_err = err_base | 4'b0011;
      if (c == exp_q.size() - 1) m_done = 1'b1;
      chk("stream_vec", 16'(vec()), 16'(exp_q[c]));
      chk("stream_status", 16'(status_reg), 16'(st(c != exp_q.size() - 1)));
      if (out_valid && ov_cycle == 0) ov_cycle = c + 1;
    end
    ctrl_reg   = 8'h00;
    wr_en_push = 1'b0;
    is_weight  = 1'b0;
    ibuf_empty = 1'b1;
    chk("latency", 16'(ov_cycle), 16'(Lat + stalls));
    tick();
    chk("stream_end_vec", 16'(vec()), 16'h0);
    chk("stream_end_status", 16'(status_reg), 16'(st(1'b0)));
  endtask

  initial begin
    rst        = 1'b1;
    ctrl_reg   = 8'h00;
    wr_en_push = 1'b0;
    is_weight  = 1'b0;
    wbuf_empty = 1'b1;
    ibuf_empty = 1'b1;
    tick();
    tick();
    chk("reset_vec", 16'(vec()), 16'h0);
    chk("reset_status", 16'(status_reg), 16'h0);
    chk("reset_err", err_reg, 16'h0);
    rst = 1'b0;

    // Start with no weights loaded.
    pulse(8'h01);
    m_err = 4'h4;
    chk("nowt_err", err_reg, 16'h0004);
    chk("nowt_status", 16'(status_reg), 16'h0008);
    chk("nowt_vec", 16'(vec()), 16'h0);
    tick();
    chk("nowt_idle", 16'(vec()), 16'h0);
    pulse(8'h80);
    m_err = 4'h0;
    chk("clr_err", err_reg, 16'h0);

    // Input overflow on the fifth unpopped push.
    push_rows(1'b0, 4);
    chk("ovf_none", err_reg, 16'h0);
    push_rows(1'b0, 1);
    m_err = 4'h8;
    chk("ovf_err", err_reg, 16'h0008);
    chk("ovf_status", 16'(status_reg), 16'h0008);
    pulse(8'h80);
    m_err = 4'h0;
    chk("ovf_clr", err_reg, 16'h0);

    // Clean load and tile.
    push_rows(1'b1, 4);
    do_load(8'h02, 1'b0);
    chk("load_status_04", 16'(status_reg), 16'h0004);
    push_rows(1'b0, 4);
    do_stream(0, 0, 1'b0, 1'b0);
    chk("tile_status_06", 16'(status_reg), 16'h0006);
    pulse(8'h80);
    m_done = 1'b0;
    chk("clr_done", 16'(status_reg), 16'h0004);

    // Three-cycle input stall mid-stream.
    push_rows(1'b0, 4);
    do_stream(2, 3, 1'b0, 1'b0);

    // Busy errors injected during stream; tile timing must be unaffected.
    push_rows(1'b0, 4);
    do_stream(0, 0, 1'b0, 1'b1);
    chk("busy_err", err_reg, 16'h0003);
    chk("busy_status", 16'(status_reg), 16'h000E);
    pulse(8'h80);
    m_err  = 4'h0;
    m_done = 1'b0;
    chk("busy_clr", 16'(status_reg), 16'h0004);

    // Randomized stalls; load pulse paired with start (load must win silently).
    for (int it = 0; it < 4; it++) begin
      push_rows(1'b1, 4);
      do_load(8'h03, 1'b1);
      push_rows(1'b0, 4);
      do_stream(0, 0, 1'b1, 1'b0);
    end
    chk("rand_err", err_reg, 16'h0);

    // Reset in the middle of the drain phase.
    push_rows(1'b0, 4);
    ctrl_reg   = 8'h01;
    ibuf_empty = 1'b0;
    tick();
    ctrl_reg = 8'h00;
    repeat (5) tick();
    chk("pre_reset_drain", 16'(vec()), 16'(VAe));
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    ibuf_empty = 1'b1;
    m_wl   = 1'b0;
    m_done = 1'b0;
    m_err  = 4'h0;
    chk("midrst_vec", 16'(vec()), 16'h0);
    chk("midrst_status", 16'(status_reg), 16'h0);
    chk("midrst_err", err_reg, 16'h0);
    tick();
    chk("midrst_idle", 16'(vec()), 16'h0);
    push_rows(1'b1, 4);
    do_load(8'h02, 1'b0);
    push_rows(1'b0, 4);
    do_stream(0, 0, 1'b0, 1'b0);
    chk("final_status", 16'(status_reg), 16'h0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inference_seq.md
Name: inference_seq

Overview:
- Sequences the systolic MAC datapath from the ahb_sub register-level controls.
- Decodes ctrl_reg edges and tracks weight/input rows pushed through ahb_sub (wr_en_push / is_weight).
- Steps the array through weight load, input stream, pipeline drain and activation.
- Generates the status_reg and err_reg values that ahb_sub exposes back to the bus.

Parameters:
- ARRAY_DIM, 4, rows/cols of the MAC array; rows per weight/input tile.
- ACT_LAT, 2, activation unit latency in cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ctrl_reg  in  8  bit0 start, bit1 load_weights, bit7 soft_clear; all level inputs, rising-edge detected internally
- wr_en_push  in  1  one row pushed into a buffer this cycle
- is_weight  in  1  qualifies wr_en_push: 1 = weight buffer, 0 = input buffer
- wbuf_empty  in  1  weight buffer empty
- ibuf_empty  in  1  input buffer empty
- wbuf_pop  out  1  pop one weight row
- ibuf_pop  out  1  pop one input row
- weight_load  out  1  array latches popped weight row this cycle
- array_en  out  1  array advances one step
- acc_clear  out  1  clear accumulators, one-cycle pulse
- act_en  out  1  activation unit enabled
- out_valid  out  1  result tile valid, one-cycle pulse
- status_reg  out  8  bit0 busy, bit1 done (sticky), bit2 weights_loaded, bit3 err_any, others 0
- err_reg  out  16  sticky error flags: bit0 start_while_busy, bit1 weight_push_while_busy, bit2 start_without_weights, bit3 input_overflow; others 0

Behaviour:
- Reset (rst=1 at posedge): state IDLE; all outputs 0; counters 0; edge-detect history 0. Reset mid-operation aborts immediately.
- Edge detect: a pulse fires when a ctrl_reg bit is 1 and was 0 last cycle. Only rising edges act; holding a bit high does nothing more.
- w_pending / i_pending: counters 0..ARRAY_DIM incremented on wr_en_push by is_weight. w_pending decrements on wbuf_pop, i_pending on ibuf_pop. Same-cycle push and pop leaves the count unchanged.
- Input overflow: a push when i_pending == ARRAY_DIM with no pop sets err bit3 and the count saturates.
- IDLE:
  - load_weights pulse -> LOAD_W, busy=1, weights_loaded cleared.
  - start pulse with weights_loaded=1 -> STREAM, acc_clear=1 that cycle, done cleared.
  - start pulse with weights_loaded=0 -> err bit2, stay IDLE.
- LOAD_W:
  - Each cycle with wbuf_empty=0: wbuf_pop=1 and weight_load=1, row count +1. wbuf_empty=1 stalls with both 0.
  - After ARRAY_DIM rows -> IDLE, weights_loaded=1, busy=0.
- STREAM:
  - Each cycle with ibuf_empty=0: ibuf_pop=1 and array_en=1. Empty stalls with both 0; array state is held.
  - After ARRAY_DIM rows -> DRAIN.
- DRAIN: array_en=1 for exactly 2*ARRAY_DIM-1 cycles, no pops -> ACT.
- ACT: act_en=1 for ACT_LAT cycles -> DONE.
- DONE: one cycle; out_valid=1, done=1, busy=0 -> IDLE.
- Busy errors:
  - start or load_weights pulse while busy: set err bit0, ignored.
  - wr_en_push with is_weight=1 while busy: set err bit1; w_pending still counts.
- Simultaneous start and load_weights pulses in IDLE: load_weights wins, start is dropped with no error.
- soft_clear pulse: clears err_reg, done and the counters; the state machine is unaffected.
- Simultaneous soft_clear and error event: the error bit is set (set wins).
- err_any = OR of err_reg.
- Latency (no stalls), start pulse to out_valid: ARRAY_DIM + (2*ARRAY_DIM-1) + ACT_LAT + 1 cycles. ARRAY_DIM=4, ACT_LAT=2 gives 14.
- All outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then load_weights edge with 4 weight rows pre-pushed -> wbuf_pop/weight_load high 4 consecutive cycles; status_reg=8'h04 afterward.
- Push 4 input rows, start edge -> acc_clear one cycle, 4 ibuf_pop, 7 array_en-only cycles, 2 act_en cycles; out_valid exactly 14 cycles after start; status_reg=8'h06.
- ibuf_empty forced high 3 cycles mid-STREAM -> pops and array_en pause 3 cycles; out_valid delayed to cycle 17.
- start edge right after reset (no weights) -> err_reg=16'h0004, status_reg=8'h08, state stays IDLE; soft_clear edge -> err_reg=0.
- start edge and weight push during STREAM -> err_reg=16'h0003; current tile still completes with correct timing.
- rst asserted mid-DRAIN -> next cycle all outputs 0 and status_reg=0; a new load and start completes normally.
